// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared encodings for the counter run sequencer
// Purpose: FSM state encoding plus direction and mode constants used by
//          counter_ctrl and its testbench.
// Ports:   none (package)
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_ctrl_core.sv
// rtl/counter_ctrl_core.sv - loadable wrapping up/down counter datapath
// Purpose: holds the counter value; synchronous load has priority over step.
// Ports:   clk, reset (sync active-low), load/load_val (parallel load),
//          en (step once), dir (0 up, 1 down), value (current count)
module counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (en) begin
            // Natural modulo-2^WIDTH wrap in both directions.
            value_q <= dir ? value_q - 1'b1 : value_q + 1'b1;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run sequencer driving the counter datapath
// Purpose: latches a run configuration on start, steps the counter from
//          start_val to end_val at the prescaled rate, reports busy/done.
// Ports:   clk, reset (sync active-low), start, abort, dir, mode,
//          start_val, end_val, prescale (run configuration inputs),
//          value (counter), busy (LOAD or RUN), done (terminal-tick pulse)
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dir,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      start_val,
    input  logic [WIDTH-1:0]      end_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  mode_q, mode_d;
    logic [WIDTH-1:0]      start_q, start_d;
    logic [WIDTH-1:0]      end_q, end_d;
    logic [PRESCALE_W-1:0] ps_q, ps_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  core_load;
    logic                  core_en;
    logic [WIDTH-1:0]      core_value;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (start_q),
        .en       (core_en),
        .dir      (dir_q),
        .value    (core_value)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
            ps_q    <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            end_q   <= end_d;
            ps_q    <= ps_d;
            pcnt_q  <= pcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        start_d   = start_q;
        end_d     = end_q;
        ps_d      = ps_q;
        pcnt_d    = pcnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    dir_d   = dir;
                    mode_d  = mode;
                    start_d = start_val;
                    end_d   = end_val;
                    ps_d    = prescale;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    core_load = 1'b1;
                    pcnt_d    = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort outranks both the prescale tick and the terminal check.
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (pcnt_q != ps_q) begin
                    pcnt_d = pcnt_q + 1'b1;
                end else begin
                    pcnt_d = '0;
                    if (core_value == end_q) begin
                        done_d = 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            core_load = 1'b1;
                        end
                    end else begin
                        core_en = 1'b1;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign value = core_value;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       dir;
    logic       mode;
    logic [7:0] start_val;
    logic [7:0] end_val;
    logic [3:0] prescale;
    logic [7:0] value;
    logic       busy;
    logic       done;

    counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .dir       (dir),
        .mode      (mode),
        .start_val (start_val),
        .end_val   (end_val),
        .prescale  (prescale),
        .value     (value),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       b;
        logic       d;
    } exp_t;

    typedef struct {
        logic [7:0] sv;
        logic [7:0] ev;
        logic       dir;
        logic [3:0] ps;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[6];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_val = 8'h00;

    task automatic step(input string tag, input logic [7:0] v, input logic b, input logic d);
        exp_t e;
        exp_t x;
        e.v = v; e.b = b; e.d = d;
        sb_q.push_back(e);
        prev_val = v;
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        checks++;
        if (value !== x.v || busy !== x.b || done !== x.d) begin
            errors++;
            $display("FAIL %s t=%0t: got value=%h busy=%b done=%b, expected value=%h busy=%b done=%b",
                     tag, $time, value, busy, done, x.v, x.b, x.d);
        end
    endtask

    task automatic set_cfg(input logic [7:0] sv, input logic [7:0] ev, input logic d, input logic m,
                           input logic [3:0] ps);
        start_val = sv; end_val = ev; dir = d; mode = m; prescale = ps;
    endtask

    // One-shot run: value after edge E(1+j) is start +/- floor(j/(ps+1)),
    // done lands on edge E(1+(N+1)(ps+1)). A stray start with scrambled
    // config is pulsed at E5 while the run is still busy.
    task automatic run_oneshot(input string tag, input vec_t t);
        logic [7:0] n;
        logic [7:0] kk;
        int         total;
        n     = t.dir ? t.sv - t.ev : t.ev - t.sv;
        total = (int'(n) + 1) * (int'(t.ps) + 1);
        set_cfg(t.sv, t.ev, t.dir, 1'b0, t.ps);
        start = 1'b1;
        step({tag, "_e0"}, prev_val, 1'b1, 1'b0);
        start = 1'b0;
        set_cfg($urandom_range(0, 255), $urandom_range(0, 255), ~t.dir, 1'b1, $urandom_range(0, 15));
        for (int j = 0; j < total; j++) begin
            kk = 8'(j / (int'(t.ps) + 1));
            if (j == 4) start = 1'b1;
            step({tag, "_run"}, t.dir ? t.sv - kk : t.sv + kk, 1'b1, 1'b0);
            start = 1'b0;
        end
        step({tag, "_done"}, t.ev, 1'b0, 1'b1);
        step({tag, "_hold"}, t.ev, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{sv: 8'h00, ev: 8'h05, dir: 1'b0, ps: 4'd0};
        vecs[1] = '{sv: 8'h02, ev: 8'hFE, dir: 1'b1, ps: 4'd0};
        vecs[2] = '{sv: 8'h10, ev: 8'h12, dir: 1'b0, ps: 4'd3};
        vecs[3] = '{sv: 8'h33, ev: 8'h33, dir: 1'b0, ps: 4'd2};
        vecs[4] = '{sv: 8'hFE, ev: 8'h01, dir: 1'b0, ps: 4'd1};
        vecs[5] = '{sv: 8'h80, ev: 8'h81, dir: 1'b1, ps: 4'd0};

        reset = 1'b0; start = 1'b1; abort = 1'b0;
        set_cfg(8'h44, 8'h55, 1'b0, 1'b0, 4'd0);
        #1;
        step("reset0", 8'h00, 1'b0, 1'b0);
        step("reset1", 8'h00, 1'b0, 1'b0);
        reset = 1'b1; start = 1'b0;
        step("idle", 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_oneshot($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort coincident with start in IDLE: no run.
        set_cfg(8'h20, 8'h30, 1'b0, 1'b0, 4'd0);
        start = 1'b1; abort = 1'b1;
        step("abort_idle", prev_val, 1'b0, 1'b0);
        start = 1'b0; abort = 1'b0;
        step("abort_idle2", prev_val, 1'b0, 1'b0);

        // Abort in LOAD: value keeps its old contents.
        start = 1'b1;
        step("abort_load_e0", prev_val, 1'b1, 1'b0);
        start = 1'b0; abort = 1'b1;
        step("abort_load", prev_val, 1'b0, 1'b0);
        abort = 1'b0;
        step("abort_load2", prev_val, 1'b0, 1'b0);

        // Auto-reload 10..12 with done on each reload, then abort.
        set_cfg(8'h10, 8'h12, 1'b0, 1'b1, 4'd0);
        start = 1'b1;
        step("reload_e0", prev_val, 1'b1, 1'b0);
        start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step("reload", 8'h10 + 8'(j % 3), 1'b1, (j > 0) && (j % 3 == 0));
        end
        abort = 1'b1;
        step("reload_abort", 8'h11, 1'b0, 1'b0);
        abort = 1'b0;
        step("reload_abort2", 8'h11, 1'b0, 1'b0);

        // Reset while value==0x03 in RUN, then a fresh run.
        set_cfg(8'h00, 8'h10, 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        step("midrst_e0", prev_val, 1'b1, 1'b0);
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step("midrst_run", 8'(j), 1'b1, 1'b0);
        end
        reset = 1'b0;
        step("midrst", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step("midrst_idle", 8'h00, 1'b0, 1'b0);
        run_oneshot("fresh", '{sv: 8'h00, ev: 8'h02, dir: 1'b0, ps: 4'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
